// File: rtl/tone_generator_pkg.sv
// Shared direction codes, FSM state encoding and default half-periods for the tone link.
// TONE_GEN_REPEAT_EN adds the GAP state used between repeated bursts.
package tone_generator_pkg;

   localparam logic [2:0] TD_HOLD     = 3'd0;
   localparam logic [2:0] TD_STRAIGHT = 3'd1;
   localparam logic [2:0] TD_LEFT     = 3'd2;
   localparam logic [2:0] TD_RIGHT    = 3'd3;
   localparam logic [2:0] TD_BACK     = 3'd4;

   localparam int HP_STRAIGHT_DEF = 25000;
   localparam int HP_LEFT_DEF     = 16667;
   localparam int HP_RIGHT_DEF    = 12500;
   localparam int HP_BACK_DEF     = 10000;

   typedef enum logic [1:0] {
`ifdef TONE_GEN_REPEAT_EN
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1,
      ST_GAP  = 2'd2
`else
      ST_IDLE = 2'd0,
      ST_TONE = 2'd1
`endif
   } state_t;

   // Only the four real directions start a burst; HOLD and undefined codes are dropped.
   function automatic logic is_tone_dir(input logic [2:0] dir);
      return (dir == TD_STRAIGHT) || (dir == TD_LEFT) ||
             (dir == TD_RIGHT)    || (dir == TD_BACK);
   endfunction

endpackage

// File: rtl/tone_half_period_div.sv
// Square-wave divider: sq toggles every halfPeriod cycles; clr restarts the phase high.
module tone_half_period_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic [25:0] halfPeriod,
   output logic        sq
);

   logic [25:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         sq    <= 1'b0;
      end else if (clr) begin
         count <= '0;
         sq    <= 1'b1;
      end else if (count == halfPeriod - 26'd1) begin
         count <= '0;
         sq    <= ~sq;
      end else begin
         count <= count + 26'd1;
      end
   end

endmodule

// File: rtl/tone_generator.sv
// Direction-to-tone transmitter: turns an accepted start+toneDir into a timed square-wave burst.
// Define TONE_GEN_REPEAT_EN for REPEATS bursts separated by GAP_CYCLES of silence.
module tone_generator
   import tone_generator_pkg::*;
#(
   parameter int TONE_CYCLES = 50_000_000,
   parameter int GAP_CYCLES  = 25_000_000,
   parameter int REPEATS     = 3,
   parameter int HP_STRAIGHT = HP_STRAIGHT_DEF,
   parameter int HP_LEFT     = HP_LEFT_DEF,
   parameter int HP_RIGHT    = HP_RIGHT_DEF,
   parameter int HP_BACK     = HP_BACK_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enableToneGen,
   input  logic       start,
   input  logic [2:0] toneDir,
   output logic       toneOut,
   output logic       busy,
   output logic       done
);

   localparam int  CNT_LIMIT = 2 ** 26;
   localparam bit  PARAMS_OK = (TONE_CYCLES >= 1) && (TONE_CYCLES < CNT_LIMIT) &&
                               (GAP_CYCLES  >= 1) && (GAP_CYCLES  < CNT_LIMIT) &&
                               (REPEATS     >= 1) && (REPEATS     < CNT_LIMIT) &&
                               (HP_STRAIGHT >= 1) && (HP_STRAIGHT < CNT_LIMIT) &&
                               (HP_LEFT     >= 1) && (HP_LEFT     < CNT_LIMIT) &&
                               (HP_RIGHT    >= 1) && (HP_RIGHT    < CNT_LIMIT) &&
                               (HP_BACK     >= 1) && (HP_BACK     < CNT_LIMIT);

   if (!PARAMS_OK) begin : g_param_check
      $error("tone_generator: a parameter is outside the 26-bit counter range");
   end

   localparam logic [25:0] TONE_LAST = 26'(TONE_CYCLES - 1);

   state_t      state;
   state_t      state_next;
   logic        done_next;
   logic        accept;
   logic        burst_last;
   logic        seq_last;
   logic [25:0] burst_cnt;
   logic [25:0] hp_q;
   logic [25:0] hp_sel;
   logic        sq;

`ifdef TONE_GEN_REPEAT_EN
   localparam logic [25:0] GAP_LAST = 26'(GAP_CYCLES - 1);
   localparam logic [25:0] REP_LAST = 26'(REPEATS - 1);
   logic [25:0] gap_cnt;
   logic [25:0] rep_cnt;
   logic        gap_last;
`endif

   always_comb begin
      hp_sel = '0;
      case (toneDir)
         TD_STRAIGHT: hp_sel = 26'(HP_STRAIGHT);
         TD_LEFT:     hp_sel = 26'(HP_LEFT);
         TD_RIGHT:    hp_sel = 26'(HP_RIGHT);
         TD_BACK:     hp_sel = 26'(HP_BACK);
         default:     hp_sel = '0;
      endcase
   end

   // Next-state logic; a low enable wins over everything, including a same-cycle start.
   always_comb begin
      state_next = state;
      done_next  = 1'b0;
      accept     = start && enableToneGen && (state == ST_IDLE) && is_tone_dir(toneDir);
      burst_last = (burst_cnt == TONE_LAST);
`ifdef TONE_GEN_REPEAT_EN
      gap_last   = (gap_cnt == GAP_LAST);
      seq_last   = burst_last && (rep_cnt == REP_LAST);
`else
      seq_last   = burst_last;
`endif
      if (!enableToneGen) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) state_next = ST_TONE;
            end
            ST_TONE: begin
               if (seq_last) begin
                  state_next = ST_IDLE;
                  done_next  = 1'b1;
               end
`ifdef TONE_GEN_REPEAT_EN
               else if (burst_last) begin
                  state_next = ST_GAP;
               end
`endif
            end
`ifdef TONE_GEN_REPEAT_EN
            ST_GAP: begin
               if (gap_last) state_next = ST_TONE;
            end
`endif
            default: state_next = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         done  <= done_next;
      end
   end

   // Counters only run while their state persists, so each burst and gap starts from zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt <= '0;
         hp_q      <= '0;
      end else begin
         if (accept) hp_q <= hp_sel;
         burst_cnt <= (state == ST_TONE && state_next == ST_TONE) ? burst_cnt + 26'd1 : '0;
      end
   end

`ifdef TONE_GEN_REPEAT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gap_cnt <= '0;
         rep_cnt <= '0;
      end else begin
         gap_cnt <= (state == ST_GAP && state_next == ST_GAP) ? gap_cnt + 26'd1 : '0;
         if (state_next == ST_IDLE) rep_cnt <= '0;
         else if (state == ST_TONE && state_next == ST_GAP) rep_cnt <= rep_cnt + 26'd1;
      end
   end
`endif

   // Holding the divider clear outside TONE makes every burst open with a high half-period.
   tone_half_period_div u_div (
      .clk        (clk),
      .rst        (rst),
      .clr        (state != ST_TONE),
      .halfPeriod (hp_q),
      .sq         (sq)
   );

   assign toneOut = (state == ST_TONE) && sq;
   assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_tone_generator.sv
// Scoreboard bench for tone_generator: per-cycle expected toneOut/busy/done queued at stimulus time.
// Expectations follow TONE_GEN_REPEAT_EN when it is defined for the build.
module tb_tone_generator;
   import tone_generator_pkg::*;

   localparam int TONE_CYCLES = 40;
   localparam int GAP_CYCLES  = 10;
   localparam int REPEATS     = 2;
`ifdef TONE_GEN_REPEAT_EN
   localparam int SEQ_LEN = REPEATS * TONE_CYCLES + (REPEATS - 1) * GAP_CYCLES + 1;
`else
   localparam int SEQ_LEN = TONE_CYCLES + 1;
`endif

   typedef struct packed {
      logic tone;
      logic busy;
      logic done;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       enableToneGen;
   logic       start;
   logic [2:0] toneDir;
   logic       toneOut;
   logic       busy;
   logic       done;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   tone_generator #(
      .TONE_CYCLES (TONE_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES),
      .REPEATS     (REPEATS),
      .HP_STRAIGHT (4),
      .HP_LEFT     (3),
      .HP_RIGHT    (2),
      .HP_BACK     (1)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .enableToneGen (enableToneGen),
      .start         (start),
      .toneDir       (toneDir),
      .toneOut       (toneOut),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   function automatic int hpOf(input logic [2:0] dir);
      case (dir)
         TD_STRAIGHT: return 4;
         TD_LEFT:     return 3;
         TD_RIGHT:    return 2;
         default:     return 1;
      endcase
   endfunction

   task automatic pushEntry(input logic t, input logic b, input logic d);
      exp_t e;
      e.tone = t;
      e.busy = b;
      e.done = d;
      exp_q.push_back(e);
   endtask

   task automatic pushIdle(input int n);
      for (int i = 0; i < n; i++) pushEntry(1'b0, 1'b0, 1'b0);
   endtask

   task automatic pushBurst(input int hp, input int n);
      for (int k = 0; k < n; k++) pushEntry(((k / hp) % 2) == 0, 1'b1, 1'b0);
   endtask

   // Full command: burst(s), gaps when repeating, then the single done cycle.
   task automatic pushSequence(input logic [2:0] dir);
`ifdef TONE_GEN_REPEAT_EN
      for (int r = 0; r < REPEATS; r++) begin
         pushBurst(hpOf(dir), TONE_CYCLES);
         if (r < REPEATS - 1) begin
            for (int g = 0; g < GAP_CYCLES; g++) pushEntry(1'b0, 1'b1, 1'b0);
         end
      end
`else
      pushBurst(hpOf(dir), TONE_CYCLES);
`endif
      pushEntry(1'b0, 1'b0, 1'b1);
   endtask

   task automatic applyStimulus(input logic s, input logic [2:0] dir);
      start   = s;
      toneDir = dir;
   endtask

   task automatic checkOutput(input string tag);
      exp_t e;
      total++;
      assert (exp_q.size() != 0) else begin
         bad++;
         $error("FAIL %s scoreboard_empty observed=0 required=1", tag);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total++;
         assert (toneOut === e.tone) else begin
            bad++;
            $error("FAIL %s toneOut observed=%b required=%b", tag, toneOut, e.tone);
         end
         total++;
         assert (busy === e.busy) else begin
            bad++;
            $error("FAIL %s busy observed=%b required=%b", tag, busy, e.busy);
         end
         total++;
         assert (done === e.done) else begin
            bad++;
            $error("FAIL %s done observed=%b required=%b", tag, done, e.done);
         end
      end
   endtask

   task automatic runCycles(input int n, input string tag);
      repeat (n) begin
         @(negedge clk);
         checkOutput(tag);
         start = 1'b0;
      end
   endtask

   initial begin
      rst           = 1'b1;
      enableToneGen = 1'b1;
      applyStimulus(1'b0, TD_HOLD);

      $display("[TB] reset state");
      pushIdle(2);
      runCycles(2, "reset_hold");
      rst = 1'b0;
      pushIdle(2);
      runCycles(2, "reset_release");

      $display("[TB] straight burst");
      applyStimulus(1'b1, TD_STRAIGHT);
      pushSequence(TD_STRAIGHT);
      pushIdle(2);
      runCycles(SEQ_LEN + 2, "straight");

      $display("[TB] left then right accepted in the done cycle");
      applyStimulus(1'b1, TD_LEFT);
      pushSequence(TD_LEFT);
      runCycles(SEQ_LEN, "left");
      applyStimulus(1'b1, TD_RIGHT);
      pushSequence(TD_RIGHT);
      runCycles(SEQ_LEN, "right");
      pushIdle(2);
      runCycles(2, "right_idle");

      $display("[TB] back burst");
      applyStimulus(1'b1, TD_BACK);
      pushSequence(TD_BACK);
      pushIdle(2);
      runCycles(SEQ_LEN + 2, "back");

      $display("[TB] ignored commands");
      applyStimulus(1'b1, TD_HOLD);
      pushIdle(3);
      runCycles(3, "hold_ignored");
      applyStimulus(1'b1, 3'd7);
      pushIdle(3);
      runCycles(3, "undef_ignored");

      $display("[TB] start while busy");
      applyStimulus(1'b1, TD_STRAIGHT);
      pushSequence(TD_STRAIGHT);
      pushIdle(2);
      runCycles(10, "busy_start_pre");
      applyStimulus(1'b1, TD_BACK);
      runCycles(SEQ_LEN - 8, "busy_start_post");

      $display("[TB] enable drop mid-burst");
      applyStimulus(1'b1, TD_STRAIGHT);
      pushBurst(4, 15);
      runCycles(15, "enable_pre");
      enableToneGen = 1'b0;
      pushIdle(3);
      runCycles(3, "enable_drop");
      applyStimulus(1'b1, TD_LEFT);
      pushIdle(3);
      runCycles(3, "enable_low_start");
      enableToneGen = 1'b1;
      pushIdle(2);
      runCycles(2, "enable_restore");

      $display("[TB] reset mid-burst");
      applyStimulus(1'b1, TD_STRAIGHT);
      pushBurst(4, 10);
      runCycles(10, "rst_pre");
      rst = 1'b1;
      #1;
      total++;
      assert (toneOut === 1'b0) else begin
         bad++;
         $error("FAIL rst_async toneOut observed=%b required=0", toneOut);
      end
      total++;
      assert (busy === 1'b0) else begin
         bad++;
         $error("FAIL rst_async busy observed=%b required=0", busy);
      end
      total++;
      assert (done === 1'b0) else begin
         bad++;
         $error("FAIL rst_async done observed=%b required=0", done);
      end
      pushIdle(2);
      runCycles(2, "rst_held");
      rst = 1'b0;
      pushIdle(1);
      runCycles(1, "rst_released");
      applyStimulus(1'b1, TD_RIGHT);
      pushSequence(TD_RIGHT);
      pushIdle(2);
      runCycles(SEQ_LEN + 2, "after_rst");

      total++;
      assert (exp_q.size() == 0) else begin
         bad++;
         $error("FAIL scoreboard_leftover observed=%0d required=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
